// File: rtl/sample_acquisition_seq_pkg.sv
// ---------------------------------------------------------------------------
// sample_acquisition_seq_pkg
// Shared definitions for the sample acquisition sequencer and the blocks
// around it: FSM state encoding, STATUS bit positions, the default idle
// azmux selection, azmux source constants, and the effective sequence
// length rule.
// No ports (package).
// ---------------------------------------------------------------------------
package sample_acquisition_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SETTLE     = 2'd1,
        ST_TRIG       = 2'd2,
        ST_WAIT_VALID = 2'd3
    } seq_state_t;

    // status_o = {running, state[1:0]}
    localparam int STATUS_RUNNING_BIT = 2;
    localparam int STATUS_STATE_MSB   = 1;
    localparam int STATUS_STATE_LSB   = 0;

    localparam int AZMUX_IDLE_DEFAULT = 0;

    // azmux input sources on the analog board
    localparam logic [3:0] AZMUX_S1 = 4'd1;
    localparam logic [3:0] AZMUX_S2 = 4'd2;
    localparam logic [3:0] AZMUX_S3 = 4'd3;
    localparam logic [3:0] AZMUX_S4 = 4'd4;
    localparam logic [3:0] AZMUX_S5 = 4'd5;
    localparam logic [3:0] AZMUX_S6 = 4'd6;
    localparam logic [3:0] AZMUX_S7 = 4'd7;
    localparam logic [3:0] AZMUX_S8 = 4'd8;

    // A programmed length of 0 still runs one step; anything beyond the
    // table size runs the whole table.
    function automatic int eff_seq_len(input int len, input int max_steps);
        if (len < 1) begin
            return 1;
        end
        if (len > max_steps) begin
            return max_steps;
        end
        return len;
    endfunction

endpackage

// File: rtl/sample_acquisition_seq_if.sv
// ---------------------------------------------------------------------------
// sample_acquisition_seq_if
// Groups the sequencer's register-set inputs, ADC handshake and output-mux
// signals.
//   master : the surrounding system (SPI register set, ADC, output mux)
//   slave  : the sequencer itself
// Signals:
//   arm_trigger_i, p_seq_len_i, p_azmux_vals_i, p_pc_mask_i, p_sw_pc_sel_i,
//   p_clk_count_precharge_i, adc_measure_valid_i      (into the sequencer)
//   adc_measure_trig_o, azmux_o, sw_pc_o, step_idx_o, seq_count_o,
//   meas_complete_o, led0_o, status_o, monitor_o       (out of the sequencer)
// ---------------------------------------------------------------------------
interface sample_acquisition_seq_if #(
    parameter int NUM_STEPS = 4,
    parameter int AZMUX_W   = 4,
    parameter int SW_PC_W   = 2,
    parameter int CNT_W     = 24,
    parameter int STEP_W    = 3
);
    logic                           arm_trigger_i;
    logic [STEP_W-1:0]              p_seq_len_i;
    logic [NUM_STEPS*AZMUX_W-1:0]   p_azmux_vals_i;
    logic [NUM_STEPS-1:0]           p_pc_mask_i;
    logic [SW_PC_W-1:0]             p_sw_pc_sel_i;
    logic [CNT_W-1:0]               p_clk_count_precharge_i;
    logic                           adc_measure_valid_i;

    logic                           adc_measure_trig_o;
    logic [AZMUX_W-1:0]             azmux_o;
    logic [SW_PC_W-1:0]             sw_pc_o;
    logic [STEP_W-1:0]              step_idx_o;
    logic [15:0]                    seq_count_o;
    logic                           meas_complete_o;
    logic                           led0_o;
    logic [2:0]                     status_o;
    logic [1:0]                     monitor_o;

    modport master (
        output arm_trigger_i, p_seq_len_i, p_azmux_vals_i, p_pc_mask_i,
               p_sw_pc_sel_i, p_clk_count_precharge_i, adc_measure_valid_i,
        input  adc_measure_trig_o, azmux_o, sw_pc_o, step_idx_o, seq_count_o,
               meas_complete_o, led0_o, status_o, monitor_o
    );

    modport slave (
        input  arm_trigger_i, p_seq_len_i, p_azmux_vals_i, p_pc_mask_i,
               p_sw_pc_sel_i, p_clk_count_precharge_i, adc_measure_valid_i,
        output adc_measure_trig_o, azmux_o, sw_pc_o, step_idx_o, seq_count_o,
               meas_complete_o, led0_o, status_o, monitor_o
    );
endinterface

// File: rtl/sample_acquisition_seq_clk_down_counter.sv
// ---------------------------------------------------------------------------
// sample_acquisition_seq_clk_down_counter
// Loadable down counter that stops at zero. Reused by the ADC test block.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   load         : load load_value (wins over count_en)
//   load_value   : value to load
//   count_en     : decrement by one per cycle while non-zero
//   zero         : counter currently holds zero
// ---------------------------------------------------------------------------
module sample_acquisition_seq_clk_down_counter #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             count_en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count_en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/sample_acquisition_seq.sv
// ---------------------------------------------------------------------------
// sample_acquisition_seq
// Steps through a programmable list of azmux selections. Each step drives
// its azmux value and (optionally) the precharge switches, waits a settle
// interval, pulses the ADC trigger and waits for the ADC valid handshake.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : sample_acquisition_seq_if.slave (register set, ADC
//                handshake, output-mux signals)
// ---------------------------------------------------------------------------
module sample_acquisition_seq
    import sample_acquisition_seq_pkg::*;
#(
    parameter int NUM_STEPS  = 4,
    parameter int AZMUX_W    = 4,
    parameter int SW_PC_W    = 2,
    parameter int CNT_W      = 24,
    parameter int STEP_W     = 3,
    parameter int AZMUX_IDLE = AZMUX_IDLE_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    sample_acquisition_seq_if.slave bus
);

    localparam logic [AZMUX_W-1:0] AZMUX_IDLE_V = AZMUX_W'(AZMUX_IDLE);

    seq_state_t state, state_next;
    logic [STEP_W-1:0] k, k_next;

    // Register-set snapshot taken when a run is armed from IDLE
    logic [NUM_STEPS*AZMUX_W-1:0] sh_vals;
    logic [NUM_STEPS-1:0]         sh_mask;
    logic [SW_PC_W-1:0]           sh_sel;
    logic [STEP_W-1:0]            sh_last;

    logic                         latch_shadow;
    logic                         enter_step;
    logic [STEP_W-1:0]            enter_k;
    logic [NUM_STEPS*AZMUX_W-1:0] src_vals, vals_shifted;
    logic [NUM_STEPS-1:0]         src_mask, mask_shifted;
    logic [SW_PC_W-1:0]           src_sel;

    logic cnt_load, cnt_zero, cnt_en;

    logic               trig_q, trig_next;
    logic [AZMUX_W-1:0] azmux_q, azmux_next;
    logic [SW_PC_W-1:0] sw_pc_q, sw_pc_next;
    logic [STEP_W-1:0]  step_idx_q, step_idx_next;
    logic [15:0]        seq_count_q, seq_count_next;
    logic               meas_q, meas_next;
    logic               led_q, led_next;
    logic [2:0]         status_q, status_next;
    logic [1:0]         monitor_q, monitor_next;

    assign cnt_en = (state == ST_SETTLE);

    sample_acquisition_seq_clk_down_counter #(
        .CNT_W (CNT_W)
    ) u_settle_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (bus.p_clk_count_precharge_i),
        .count_en   (cnt_en),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            k     <= '0;
        end else begin
            state <= state_next;
            k     <= k_next;
        end
    end

    always_comb begin
        state_next     = state;
        k_next         = k;
        latch_shadow   = 1'b0;
        enter_step     = 1'b0;
        enter_k        = '0;
        cnt_load       = 1'b0;
        trig_next      = 1'b0;
        meas_next      = 1'b0;
        azmux_next     = azmux_q;
        sw_pc_next     = sw_pc_q;
        step_idx_next  = step_idx_q;
        seq_count_next = seq_count_q;
        led_next       = led_q;

        case (state)
            ST_IDLE: begin
                azmux_next = AZMUX_IDLE_V;
                sw_pc_next = '0;
                if (bus.arm_trigger_i) begin
                    latch_shadow = 1'b1;
                    k_next       = '0;
                    enter_step   = 1'b1;
                    enter_k      = '0;
                    state_next   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    trig_next  = 1'b1;
                    state_next = ST_TRIG;
                end
            end
            ST_TRIG: begin
                state_next = ST_WAIT_VALID;
            end
            ST_WAIT_VALID: begin
                if (bus.adc_measure_valid_i) begin
                    meas_next     = 1'b1;
                    step_idx_next = k;
                    if (k == sh_last) begin
                        k_next         = '0;
                        seq_count_next = seq_count_q + 16'd1;
                        led_next       = ~led_q;
                    end else begin
                        k_next = k + STEP_W'(1);
                    end
                    if (bus.arm_trigger_i) begin
                        enter_step = 1'b1;
                        enter_k    = k_next;
                        state_next = ST_SETTLE;
                    end else begin
                        azmux_next = AZMUX_IDLE_V;
                        sw_pc_next = '0;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // The first step of a run reads the live register set because the
        // snapshot is only captured on that same edge.
        src_vals     = latch_shadow ? bus.p_azmux_vals_i : sh_vals;
        src_mask     = latch_shadow ? bus.p_pc_mask_i    : sh_mask;
        src_sel      = latch_shadow ? bus.p_sw_pc_sel_i  : sh_sel;
        vals_shifted = src_vals >> (int'(enter_k) * AZMUX_W);
        mask_shifted = src_mask >> enter_k;
        if (enter_step) begin
            azmux_next = vals_shifted[AZMUX_W-1:0];
            sw_pc_next = mask_shifted[0] ? src_sel : '0;
            cnt_load   = 1'b1;
        end

        status_next = '0;
        status_next[STATUS_RUNNING_BIT] = (state_next != ST_IDLE);
        status_next[STATUS_STATE_MSB:STATUS_STATE_LSB] = state_next;
        monitor_next = {trig_next, |sw_pc_next};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh_vals <= '0;
            sh_mask <= '0;
            sh_sel  <= '0;
            sh_last <= '0;
        end else if (latch_shadow) begin
            sh_vals <= bus.p_azmux_vals_i;
            sh_mask <= bus.p_pc_mask_i;
            sh_sel  <= bus.p_sw_pc_sel_i;
            sh_last <= STEP_W'(eff_seq_len(int'(bus.p_seq_len_i), NUM_STEPS) - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            trig_q      <= 1'b0;
            azmux_q     <= AZMUX_IDLE_V;
            sw_pc_q     <= '0;
            step_idx_q  <= '0;
            seq_count_q <= '0;
            meas_q      <= 1'b0;
            led_q       <= 1'b0;
            status_q    <= '0;
            monitor_q   <= '0;
        end else begin
            trig_q      <= trig_next;
            azmux_q     <= azmux_next;
            sw_pc_q     <= sw_pc_next;
            step_idx_q  <= step_idx_next;
            seq_count_q <= seq_count_next;
            meas_q      <= meas_next;
            led_q       <= led_next;
            status_q    <= status_next;
            monitor_q   <= monitor_next;
        end
    end

    assign bus.adc_measure_trig_o = trig_q;
    assign bus.azmux_o            = azmux_q;
    assign bus.sw_pc_o            = sw_pc_q;
    assign bus.step_idx_o         = step_idx_q;
    assign bus.seq_count_o        = seq_count_q;
    assign bus.meas_complete_o    = meas_q;
    assign bus.led0_o             = led_q;
    assign bus.status_o           = status_q;
    assign bus.monitor_o          = monitor_q;

endmodule

// File: doc/sample_acquisition_seq.md
Name: sample_acquisition_seq

Overview:
Parametrised successor to the fixed hi/lo auto-zero sample acquisition sequencer. It steps through a programmable list of up to NUM_STEPS azmux input selections, each with its own precharge-switch mask. For each step it waits a settle/precharge interval, triggers the ADC and waits for the ADC's valid handshake. It sits between the SPI register set (parameters, arm) and the mode/AF output mux (azmux, pc switch, monitor, led, meas_complete).

Parameters:
NUM_STEPS, 4, maximum sequence length (>=1)
AZMUX_W, 4, azmux select width
SW_PC_W, 2, number of precharge switch outputs
CNT_W, 24, precharge counter width
STEP_W, 3, width of seq length/index fields (must hold NUM_STEPS)
AZMUX_IDLE, 0, azmux value driven when not running

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
arm_trigger_i  in  1  level; high = run continuously
p_seq_len_i  in  STEP_W  number of active steps
p_azmux_vals_i  in  NUM_STEPS*AZMUX_W  step k value at bits [k*AZMUX_W +: AZMUX_W]
p_pc_mask_i  in  NUM_STEPS  bit k=1: step k drives precharge switches
p_sw_pc_sel_i  in  SW_PC_W  which pc switches to drive when enabled
p_clk_count_precharge_i  in  CNT_W  settle interval, clocks
adc_measure_valid_i  in  1  one-cycle pulse from ADC, result ready
adc_measure_trig_o  out  1  one-cycle ADC start pulse
azmux_o  out  AZMUX_W  azmux select
sw_pc_o  out  SW_PC_W  precharge switch controls
step_idx_o  out  STEP_W  index of last completed step
seq_count_o  out  16  completed full sequences, wraps
meas_complete_o  out  1  one-cycle pulse per completed step
led0_o  out  1  toggles per completed sequence
status_o  out  3  {running, state[1:0]}
monitor_o  out  2  {adc_measure_trig_o, |sw_pc_o}

Behaviour:
- All outputs registered.
- Reset values: trig 0, azmux AZMUX_IDLE, sw_pc 0, step_idx 0, seq_count 0, meas_complete 0, led0 0, status 0, monitor 0. State is IDLE and the step pointer is 0.
- States:
  - IDLE=0.
  - SETTLE=1.
  - TRIG=2.
  - WAIT_VALID=3.
- IDLE:
  - Outputs are at idle values.
  - When arm_trigger_i is sampled high, latch a shadow copy of seq_len, azmux_vals, pc_mask and sw_pc_sel. Enter SETTLE with k=0.
- Effective length:
  - seq_len=0 is treated as 1.
  - seq_len>NUM_STEPS is clamped to NUM_STEPS.
  - SPI writes during a run have no effect until the next arm from IDLE.
- SETTLE entry:
  - azmux_o = shadow val[k].
  - sw_pc_o = mask[k] ? sel : 0.
  - Counter loads p_clk_count_precharge_i, sampled per step.
  - SETTLE lasts P+1 cycles; P=0 gives 1 cycle.
- TRIG: adc_measure_trig_o is high for exactly one cycle, then WAIT_VALID.
- WAIT_VALID:
  - Hold azmux_o and sw_pc_o.
  - When adc_measure_valid_i is seen: step_idx_o<=k and meas_complete_o pulses 1 cycle.
  - If k was the last step: k<=0, seq_count_o increments (wraps 0xFFFF->0) and led0_o toggles.
  - If arm_trigger_i is high on that cycle, go to SETTLE with the next k. Otherwise go to IDLE, with outputs at idle values on the next cycle.
- Arm deasserted mid-step: the current step runs to completion; it is never aborted.
- Valid pulses outside WAIT_VALID, including during TRIG, are ignored.
- Latency: arm sampled at edge n gives azmux valid from n+1 and trig high on cycle n+1+(P+1).
- Reset mid-operation returns everything to reset values on the next edge. No trig pulse is emitted after reset.
- No timeout. With no valid, the block stays in WAIT_VALID until reset or valid arrives.

Decomposition:
- Shared package (sa_pkg): state encodings, STATUS bit positions, AZMUX_IDLE default, azmux source constants (S1..S8).
- Sub-module: clk_down_counter (load, count-to-zero flag, CNT_W parametrised), reusable by the ADC test block.

Test Plan:
1. Reset: assert reset 2 cycles mid-run -> all outputs at reset values next cycle, trig never pulses afterwards.
2. Single run:
   - Stimulus: seq_len=2, vals={0x7,0x1}, pc_mask=2'b01, sel=2'b10, P=3, arm high at cycle 0.
   - Response: azmux=0x1 and sw_pc=2'b10 cycles 1-5, trig at cycle 5. Bench valid at cycle 7 -> meas_complete at 8, step_idx=0. Then azmux=0x7, sw_pc=0.
3. Wrap: continue arm -> after step 1 valid, seq_count=1, led0=1, k back to 0 (azmux=0x1). After a second full sequence, seq_count=2 and led0=0.
4. Disarm mid-step: drop arm during SETTLE of step 1 -> trig and valid still complete that step, then azmux=AZMUX_IDLE and status running=0.
5. Bounds: seq_len=0 -> only step 0 repeats. seq_len=7 with NUM_STEPS=4 -> steps 0..3 then wrap. P=0 -> trig 2 cycles after arm.
6. Stray handshake: valid pulses in IDLE and during TRIG -> ignored. Block still waits for a valid in WAIT_VALID, with no meas_complete from the stray pulses.
